cc_counter: RTL and testbench
=============================

// Module: cc_counter
// PURPOSE
//   Parametrised WIDTH-bit sequential arithmetic register (counter/accumulator) for genesis3.
//   Supports count up, count down, add operand and subtract operand, with optional saturation.
//   The next-state adder is an explicit per-bit propagate/generate ripple chain
//   (cout = p ? cin : g, sum = p ^ cin), so synthesis maps it onto fa_1bit carry cells.
//   State is held in dffre-style flops. Used for timers, address generators and accumulators.
// PARAMETERS
//   WIDTH       8                 data/counter width in bits, >= 2
//   SATURATE    0                 0 = wrap modulo 2^WIDTH; 1 = clamp at all-ones / zero
//   INIT_VALUE  {WIDTH{1'b0}}     simulation power-up value of Q, not synthesised
// PORTS
//   C    input   1      clock, rising edge
//   R    input   1      asynchronous reset, active-low
//   E    input   1      operation enable, active-high
//   LD   input   1      synchronous load, active-high, overrides E
//   D    input   WIDTH  load data
//   MODE input   2      00 = +1, 01 = -1, 10 = +A, 11 = -A
//   A    input   WIDTH  operand for MODE 10/11
//   Q    output  WIDTH  registered count/accumulator value
//   CO   output  1      registered carry-out of last executed operation
//   TC   output  1      combinational terminal count
// BEHAVIOUR
//   Reset
//   - R=0 clears Q=0 and CO=0 immediately, independent of C.
//   - While R=0, all edges on C are ignored.
//   - The first rising edge of C after R returns to 1 operates normally.
//   - Reset mid-operation discards the in-flight result; no partial update.
//   Power-up (simulation only)
//   - Q=INIT_VALUE, CO=0.
//   Edge priority, per rising edge of C: R=0 > LD=1 > E=1 > hold.
//   - LD=1: Q<=D, CO<=0. E and MODE are ignored.
//   - E=0 and LD=0: Q and CO hold.
//   - E=1 and LD=0: Q<=S, CO<=cout, from the chain Q + B + cin:
//       MODE 00: B=0,        cin=1
//       MODE 01: B=all-ones, cin=0
//       MODE 10: B=A,        cin=0
//       MODE 11: B=~A,       cin=1
//   - Per bit i: p=Q[i]^B[i]; g=Q[i]&B[i]; S[i]=p^c[i]; c[i+1]=p?c[i]:g.
//     c[0]=cin; cout=c[WIDTH].
//   - CO meaning:
//       MODE 00/10: CO=1 means unsigned overflow.
//       MODE 01/11: CO=1 means no borrow; CO=0 means unsigned underflow.
//   - SATURATE=1 overrides S, but CO always records the raw cout:
//       MODE 00/10 with cout=1: Q<=all-ones.
//       MODE 01/11 with cout=0: Q<=0.
//   - SATURATE=0: Q wraps modulo 2^WIDTH.
//   - Latency: one cycle from the sampling edge to the Q/CO update. No internal pipelining.
//   Terminal count
//   - TC = (MODE==00 && Q==all-ones) || (MODE==01 && Q==0).
//   - TC is 0 for MODE 10/11 and while R=0.
//   - TC is purely combinational from Q and MODE and does not depend on E.
//   Simultaneous events
//   - LD with E: load wins.
//   - A and MODE are sampled only on an enabled edge.
//   - X on E or LD outside reset propagates X to Q in simulation.
// TESTING (WIDTH=8 unless stated)
//   1. Reset: R=0 with no clock -> Q=00, CO=0, TC=0.
//      Then R=1, E=1, MODE=00, 3 edges -> Q=03, CO=0.
//   2. Up wrap: LD D=FE, then E=1, MODE=00.
//      Edge 1 -> Q=FF, CO=0, TC=1. Edge 2 -> Q=00, CO=1, TC=0.
//   3. Down borrow: LD D=01, then E=1, MODE=01.
//      Edge 1 -> Q=00, CO=1, TC=1. Edge 2 -> Q=FF, CO=0.
//   4. Add/sub: LD D=64.
//      MODE=10, A=9C -> Q=00, CO=1. Then MODE=11, A=01 -> Q=FF, CO=0.
//   5. SATURATE=1: LD F0, MODE=10, A=20 -> Q=FF, CO=1.
//      Then LD 10, MODE=11, A=FF -> Q=00, CO=0.
//   6. Priority:
//      E=0, LD=1, D=5A -> Q=5A, CO=0.
//      E=0, LD=0 for 4 edges -> Q stays 5A.
//      R pulsed low between edges -> Q=00 before the next edge.

Source files
------------

// File: rtl/cc_counter.sv
// cc_counter: WIDTH-bit sequential arithmetic register (counter / accumulator).
//
// Each enabled clock edge computes Q + B + cin through an explicit per-bit
// propagate/generate ripple chain (cout = p ? cin : g, sum = p ^ cin). The
// chain is written this way so that synthesis maps it onto 1-bit full-adder
// carry cells. The result is optionally clamped at all-ones or zero.
//
// Parameters
//   WIDTH       data/counter width in bits (>= 2)
//   SATURATE    0 = wrap modulo 2^WIDTH, 1 = clamp at all-ones / zero
//   INIT_VALUE  power-up value of Q (simulation only)
//
// Ports
//   C     in   clock, rising edge
//   R     in   asynchronous reset, active-low (clears Q and CO)
//   E     in   operation enable
//   LD    in   synchronous load of D, overrides E
//   D     in   load data
//   MODE  in   00 = +1, 01 = -1, 10 = +A, 11 = -A
//   A     in   operand for MODE 10/11
//   Q     out  registered count/accumulator value
//   CO    out  registered carry-out of the last executed operation
//                (add: 1 = overflow, subtract: 1 = no borrow)
//   TC    out  combinational terminal count
module cc_counter #(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       SATURATE   = 0,
  parameter logic [WIDTH-1:0]  INIT_VALUE = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             TC
);

  // Declaration initialisers give the simulation power-up state only.
  logic [WIDTH-1:0] q_q = INIT_VALUE;
  logic             co_q = 1'b0;
  logic [WIDTH-1:0] q_d;
  logic             co_d;

  // Second adder operand and carry-in selected by MODE.
  logic [WIDTH-1:0] b_op;
  logic             cin;

  always_comb begin
    b_op = '0;
    cin  = 1'b0;
    unique case (MODE)
      2'b00: begin b_op = '0;   cin = 1'b1; end  // +1
      2'b01: begin b_op = '1;   cin = 1'b0; end  // -1 as + all-ones
      2'b10: begin b_op = A;    cin = 1'b0; end  // +A
      2'b11: begin b_op = ~A;   cin = 1'b1; end  // -A as + ~A + 1
      default: begin b_op = '0; cin = 1'b0; end
    endcase
  end

  // Propagate/generate ripple chain.
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  assign prop = q_q ^ b_op;
  assign gen  = q_q & b_op;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i]     = prop[i] ^ carry[i];
      carry[i+1] = prop[i] ? carry[i] : gen[i];
    end
  end

  logic cout;
  assign cout = carry[WIDTH];

  // MODE[0] clear means an add (+1 / +A); set means a subtract (-1 / -A).
  // Saturation only alters Q; CO always keeps the raw carry.
  logic [WIDTH-1:0] op_result;

  always_comb begin
    op_result = sum;
    if (SATURATE != 0) begin
      if (!MODE[0] && cout) begin
        op_result = '1;
      end else if (MODE[0] && !cout) begin
        op_result = '0;
      end
    end
  end

  // Ternaries rather than if/else so an X on LD or E reaches Q in simulation.
  assign q_d  = LD ? D    : (E ? op_result : q_q);
  assign co_d = LD ? 1'b0 : (E ? cout      : co_q);

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      q_q  <= '0;
      co_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      co_q <= co_d;
    end
  end

  assign Q  = q_q;
  assign CO = co_q;
  assign TC = R & (((MODE == 2'b00) && (q_q == '1)) || ((MODE == 2'b01) && (q_q == '0)));

endmodule

// File: tb/tb_cc_counter.sv
// Directed testbench for cc_counter. Two instances share every input: one
// wrapping (SATURATE=0) and one saturating (SATURATE=1), both WIDTH=8.
module tb_cc_counter;

  logic       C;
  logic       R;
  logic       E;
  logic       LD;
  logic [7:0] D;
  logic [1:0] MODE;
  logic [7:0] A;

  logic [7:0] q_w;
  logic       co_w;
  logic       tc_w;
  logic [7:0] q_s;
  logic       co_s;
  logic       tc_s;

  int errors = 0;
  int checks = 0;

  cc_counter #(
    .WIDTH   (8),
    .SATURATE(0)
  ) dut (
    .C   (C),
    .R   (R),
    .E   (E),
    .LD  (LD),
    .D   (D),
    .MODE(MODE),
    .A   (A),
    .Q   (q_w),
    .CO  (co_w),
    .TC  (tc_w)
  );

  cc_counter #(
    .WIDTH   (8),
    .SATURATE(1)
  ) dut_sat (
    .C   (C),
    .R   (R),
    .E   (E),
    .LD  (LD),
    .D   (D),
    .MODE(MODE),
    .A   (A),
    .Q   (q_s),
    .CO  (co_s),
    .TC  (tc_s)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic load(input logic [7:0] val);
    LD = 1'b1;
    E  = 1'b0;
    D  = val;
    step();
    LD = 1'b0;
  endtask

  task automatic test_reset();
    #3;  // before the first clock edge
    checks++;
    if ({q_w, co_w, tc_w} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_no_clock: got Q=%h CO=%b TC=%b want Q=00 CO=0 TC=0", q_w, co_w, tc_w);
    end
    checks++;
    if ({q_s, co_s, tc_s} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_no_clock_sat: got Q=%h CO=%b TC=%b want Q=00 CO=0 TC=0",
               q_s, co_s, tc_s);
    end
    // Edges during reset must be ignored, even with LD asserted.
    LD = 1'b1;
    E  = 1'b1;
    D  = 8'hAA;
    step();
    checks++;
    if ({q_w, co_w} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_edge_ignored: got Q=%h CO=%b want Q=00 CO=0", q_w, co_w);
    end
    R    = 1'b1;
    LD   = 1'b0;
    E    = 1'b1;
    MODE = 2'b00;
    repeat (3) step();
    checks++;
    if ({q_w, co_w} !== {8'h03, 1'b0}) begin
      errors++;
      $display("FAIL reset_count3: got Q=%h CO=%b want Q=03 CO=0", q_w, co_w);
    end
  endtask

  task automatic test_up_wrap();
    load(8'hFE);
    E    = 1'b1;
    MODE = 2'b00;
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'hFF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL up_edge1: got Q=%h CO=%b TC=%b want Q=FF CO=0 TC=1", q_w, co_w, tc_w);
    end
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL up_wrap: got Q=%h CO=%b TC=%b want Q=00 CO=1 TC=0", q_w, co_w, tc_w);
    end
    checks++;
    if ({q_s, co_s, tc_s} !== {8'hFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL up_sat_clamp: got Q=%h CO=%b TC=%b want Q=FF CO=1 TC=1", q_s, co_s, tc_s);
    end
  endtask

  task automatic test_down_borrow();
    load(8'h01);
    E    = 1'b1;
    MODE = 2'b01;
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL down_edge1: got Q=%h CO=%b TC=%b want Q=00 CO=1 TC=1", q_w, co_w, tc_w);
    end
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL down_borrow: got Q=%h CO=%b TC=%b want Q=FF CO=0 TC=0", q_w, co_w, tc_w);
    end
    checks++;
    if ({q_s, co_s, tc_s} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL down_sat_clamp: got Q=%h CO=%b TC=%b want Q=00 CO=0 TC=1", q_s, co_s, tc_s);
    end
  endtask

  task automatic test_add_sub();
    load(8'h64);
    E    = 1'b1;
    MODE = 2'b10;
    A    = 8'h9C;
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_9c: got Q=%h CO=%b TC=%b want Q=00 CO=1 TC=0", q_w, co_w, tc_w);
    end
    checks++;
    if ({q_s, co_s} !== {8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL add_9c_sat: got Q=%h CO=%b want Q=FF CO=1", q_s, co_s);
    end
    MODE = 2'b11;
    A    = 8'h01;
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_01: got Q=%h CO=%b TC=%b want Q=FF CO=0 TC=0", q_w, co_w, tc_w);
    end
    checks++;
    if ({q_s, co_s} !== {8'hFE, 1'b1}) begin
      errors++;
      $display("FAIL sub_01_sat: got Q=%h CO=%b want Q=FE CO=1", q_s, co_s);
    end
  endtask

  task automatic test_saturate();
    load(8'hF0);
    E    = 1'b1;
    MODE = 2'b10;
    A    = 8'h20;
    step();
    checks++;
    if ({q_s, co_s} !== {8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL sat_add_clamp: got Q=%h CO=%b want Q=FF CO=1", q_s, co_s);
    end
    checks++;
    if ({q_w, co_w} !== {8'h10, 1'b1}) begin
      errors++;
      $display("FAIL wrap_add_f0_20: got Q=%h CO=%b want Q=10 CO=1", q_w, co_w);
    end
    load(8'h10);
    E    = 1'b1;
    MODE = 2'b11;
    A    = 8'hFF;
    step();
    checks++;
    if ({q_s, co_s} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL sat_sub_clamp: got Q=%h CO=%b want Q=00 CO=0", q_s, co_s);
    end
    checks++;
    if ({q_w, co_w} !== {8'h11, 1'b0}) begin
      errors++;
      $display("FAIL wrap_sub_10_ff: got Q=%h CO=%b want Q=11 CO=0", q_w, co_w);
    end
  endtask

  task automatic test_priority();
    // Leave CO=1 so the load is seen to clear it.
    load(8'hFF);
    E    = 1'b1;
    MODE = 2'b00;
    step();
    LD = 1'b1;
    E  = 1'b1;
    D  = 8'h5A;
    step();
    checks++;
    if ({q_w, co_w} !== {8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL load_over_enable: got Q=%h CO=%b want Q=5A CO=0", q_w, co_w);
    end
    LD = 1'b0;
    E  = 1'b0;
    D  = 8'h33;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({q_w, co_w} !== {8'h5A, 1'b0}) begin
        errors++;
        $display("FAIL hold_edge%0d: got Q=%h CO=%b want Q=5A CO=0", i, q_w, co_w);
      end
    end
    // Mid-cycle reset: MODE=01 would give TC=1 on Q=0 if TC were not gated by R.
    MODE = 2'b01;
    R    = 1'b0;
    #2;
    checks++;
    if ({q_w, co_w, tc_w} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got Q=%h CO=%b TC=%b want Q=00 CO=0 TC=0", q_w, co_w, tc_w);
    end
    R = 1'b1;
    #1;
    checks++;
    if (tc_w !== 1'b1) begin
      errors++;
      $display("FAIL tc_after_reset: got TC=%b want TC=1", tc_w);
    end
  endtask

  task automatic test_back_to_back();
    load(8'hFD);
    E    = 1'b1;
    MODE = 2'b00;
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_fe: got Q=%h CO=%b TC=%b want Q=FE CO=0 TC=0", q_w, co_w, tc_w);
    end
    step();
    step();
    checks++;
    if ({q_w, co_w} !== {8'h00, 1'b1}) begin
      errors++;
      $display("FAIL b2b_wrap: got Q=%h CO=%b want Q=00 CO=1", q_w, co_w);
    end
    step();
    checks++;
    if ({q_w, co_w} !== {8'h01, 1'b0}) begin
      errors++;
      $display("FAIL b2b_01: got Q=%h CO=%b want Q=01 CO=0", q_w, co_w);
    end
    // A and MODE are ignored on a disabled edge.
    E    = 1'b0;
    MODE = 2'b10;
    A    = 8'h55;
    step();
    checks++;
    if ({q_w, co_w, tc_w} !== {8'h01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL disabled_add: got Q=%h CO=%b TC=%b want Q=01 CO=0 TC=0", q_w, co_w, tc_w);
    end
    E = 1'b1;
    step();
    checks++;
    if ({q_w, co_w} !== {8'h56, 1'b0}) begin
      errors++;
      $display("FAIL enabled_add: got Q=%h CO=%b want Q=56 CO=0", q_w, co_w);
    end
  endtask

  initial begin
    R    = 1'b0;
    E    = 1'b0;
    LD   = 1'b0;
    D    = 8'h00;
    MODE = 2'b00;
    A    = 8'h00;
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_add_sub();
    test_saturate();
    test_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
